// File: rtl/romulus_tk_pkg.sv
// Shared tweakey-schedule definitions: FSM states, PT cell indices and the row LFSRs.
// Every function here is pure combinational byte logic.
package romulus_tk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_HOLD = 2'd2,
    ST_REV  = 2'd3
  } tk_state_e;

  localparam int ROUNDS_DEF = 40;

  // Source cell (in rows 2-3) of each new row-0/1 cell after the PT permutation.
  localparam int PT_C0 = 9;
  localparam int PT_C1 = 15;
  localparam int PT_C2 = 8;
  localparam int PT_C3 = 13;
  localparam int PT_C4 = 10;
  localparam int PT_C5 = 14;
  localparam int PT_C6 = 12;
  localparam int PT_C7 = 11;

  function automatic int pt_src(input int i);
    case (i)
      0:       return PT_C0;
      1:       return PT_C1;
      2:       return PT_C2;
      3:       return PT_C3;
      4:       return PT_C4;
      5:       return PT_C5;
      6:       return PT_C6;
      default: return PT_C7;
    endcase
  endfunction

  function automatic logic [7:0] lfsr2(input logic [7:0] x);
    return {x[6:0], x[7] ^ x[5]};
  endfunction

  function automatic logic [7:0] lfsr3(input logic [7:0] x);
    return {x[0] ^ x[6], x[7:1]};
  endfunction

  function automatic logic [7:0] lfsr2_inv(input logic [7:0] y);
    return {y[0] ^ y[6], y[7:1]};
  endfunction

  function automatic logic [7:0] lfsr3_inv(input logic [7:0] y);
    return {y[6:0], y[7] ^ y[5]};
  endfunction

  // Mode 0 (TK1) passes cells through untouched.
  function automatic logic [7:0] lfsr_fwd(input int mode, input logic [7:0] x);
    case (mode)
      2:       return lfsr2(x);
      3:       return lfsr3(x);
      default: return x;
    endcase
  endfunction

  function automatic logic [7:0] lfsr_inv(input int mode, input logic [7:0] y);
    case (mode)
      2:       return lfsr2_inv(y);
      3:       return lfsr3_inv(y);
      default: return y;
    endcase
  endfunction

endpackage

// File: rtl/tk_half_perm.sv
// Forward (PT + row LFSR) and inverse tweakey round update of one 128-bit lane.
// Purely combinational; zero latency.
module tk_half_perm
  import romulus_tk_pkg::*;
#(
  parameter int LFSR_MODE = 0
) (
  input  logic [63:0] tkz_hi_i,
  input  logic [63:0] tkz_lo_i,
  output logic [63:0] fwd_hi_o,
  output logic [63:0] fwd_lo_o,
  output logic [63:0] inv_hi_o,
  output logic [63:0] inv_lo_o
);

  // Rows 0-1 shift down unchanged; only the permuted rows pass through the LFSR.
  assign fwd_lo_o = tkz_hi_i;
  assign inv_hi_o = tkz_lo_i;

  for (genvar i = 0; i < 8; i++) begin : g_cell
    localparam int SRC = pt_src(i) - 8;

    assign fwd_hi_o[8*i +: 8]   = lfsr_fwd(LFSR_MODE, tkz_lo_i[8*SRC +: 8]);
    assign inv_lo_o[8*SRC +: 8] = lfsr_inv(LFSR_MODE, tkz_hi_i[8*i +: 8]);
  end

endmodule

// File: rtl/tkz_schedule_32b.sv
// Tweakey-schedule stage: combinational forward/inverse lane update plus the round
// sequencer that strobes enc for ROUNDS updates, holds, then strobes se to restore.
module tkz_schedule_32b
  import romulus_tk_pkg::*;
#(
  parameter int ROUNDS    = ROUNDS_DEF,
  parameter int CYC       = 4,
  parameter int LFSR_MODE = 0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        revert_i,
  input  logic [63:0] tkz_hi_i,
  input  logic [63:0] tkz_lo_i,
  output logic [63:0] skinny_tkz_hi_o,
  output logic [63:0] skinny_tkz_lo_o,
  output logic [63:0] skinny_tkz_revert_hi_o,
  output logic [63:0] skinny_tkz_revert_lo_o,
  output logic        enc_o,
  output logic        se_o,
  output logic [5:0]  round_o,
  output logic        busy_o,
  output logic        fwd_done_o,
  output logic        done_o
);

  localparam int             CW       = $clog2(CYC);
  localparam logic [CW-1:0]  CYC_LAST = CW'(CYC - 1);
  localparam logic [CW-1:0]  CYC_PRE  = CW'(CYC - 2);
  localparam logic [5:0]     RND_LAST = 6'(ROUNDS - 1);

  tk_half_perm #(
    .LFSR_MODE (LFSR_MODE)
  ) u_perm (
    .tkz_hi_i (tkz_hi_i),
    .tkz_lo_i (tkz_lo_i),
    .fwd_hi_o (skinny_tkz_hi_o),
    .fwd_lo_o (skinny_tkz_lo_o),
    .inv_hi_o (skinny_tkz_revert_hi_o),
    .inv_lo_o (skinny_tkz_revert_lo_o)
  );

  tk_state_e      state_q;
  logic [CW-1:0]  cyc_q;
  logic [CW-1:0]  cyc_d;
  logic [5:0]     round_q;
  logic           enc_q;
  logic           se_q;
  logic           fwd_done_q;
  logic           done_q;

  assign cyc_d = (cyc_q == CYC_LAST) ? '0 : cyc_q + 1'b1;

  // Strobes are registered one cycle ahead so they line up with cyc == CYC-1.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      cyc_q      <= '0;
      round_q    <= '0;
      enc_q      <= 1'b0;
      se_q       <= 1'b0;
      fwd_done_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      enc_q      <= 1'b0;
      se_q       <= 1'b0;
      fwd_done_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q <= ST_FWD;
            cyc_q   <= '0;
            round_q <= '0;
          end
        end
        ST_FWD: begin
          cyc_q <= cyc_d;
          enc_q <= (cyc_q == CYC_PRE);
          if (cyc_q == CYC_LAST) begin
            round_q <= round_q + 6'd1;
            if (round_q == RND_LAST) begin
              state_q    <= ST_HOLD;
              fwd_done_q <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (revert_i) begin
            state_q <= ST_REV;
            cyc_q   <= '0;
          end
        end
        ST_REV: begin
          cyc_q <= cyc_d;
          se_q  <= (cyc_q == CYC_PRE);
          if (cyc_q == CYC_LAST) begin
            round_q <= round_q - 6'd1;
            if (round_q == 6'd1) begin
              state_q <= ST_IDLE;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign enc_o      = enc_q;
  assign se_o       = se_q;
  assign round_o    = round_q;
  assign busy_o     = (state_q == ST_FWD) || (state_q == ST_REV);
  assign fwd_done_o = fwd_done_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_tkz_schedule_32b.sv
// Bench for tkz_schedule_32b: three lanes (TK1/TK2/TK3) each looping through an
// external tweakey register, checked against a schedule/permutation model.
module tb_tkz_schedule_32b;

  localparam int ROUNDS = 40;
  localparam int CYC    = 4;
  localparam int PT[8]  = '{9, 15, 8, 13, 10, 14, 12, 11};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic revert = 1'b0;
  logic force_en = 1'b1;
  logic ld = 1'b0;

  logic [63:0] f_hi[3], f_lo[3], ld_hi[3], ld_lo[3], r_hi[3], r_lo[3];
  logic [63:0] t_hi[3], t_lo[3], sk_hi[3], sk_lo[3], rv_hi[3], rv_lo[3];
  logic [63:0] init_hi[3], init_lo[3];
  logic [2:0]  enc_w, se_w, busy_w, fd_w, done_w;
  logic [5:0]  rnd_w[3];

  int n_chk = 0;
  int n_pass = 0;
  int edge_n = 0;
  int enc_cnt, se_cnt, done_cnt, last_enc, last_se;
  logic [7:0] inv_tab[4][256];

  function automatic int mode_of(input int m);
    return (m == 0) ? 0 : ((m == 1) ? 2 : 3);
  endfunction

  for (genvar m = 0; m < 3; m++) begin : g_lane
    assign t_hi[m] = force_en ? f_hi[m] : r_hi[m];
    assign t_lo[m] = force_en ? f_lo[m] : r_lo[m];

    tkz_schedule_32b #(
      .ROUNDS    (ROUNDS),
      .CYC       (CYC),
      .LFSR_MODE (m == 0 ? 0 : (m == 1 ? 2 : 3))
    ) u_dut (
      .clk_i                  (clk),
      .rst_ni                 (rst_n),
      .start_i                (start),
      .revert_i               (revert),
      .tkz_hi_i               (t_hi[m]),
      .tkz_lo_i               (t_lo[m]),
      .skinny_tkz_hi_o        (sk_hi[m]),
      .skinny_tkz_lo_o        (sk_lo[m]),
      .skinny_tkz_revert_hi_o (rv_hi[m]),
      .skinny_tkz_revert_lo_o (rv_lo[m]),
      .enc_o                  (enc_w[m]),
      .se_o                   (se_w[m]),
      .round_o                (rnd_w[m]),
      .busy_o                 (busy_w[m]),
      .fwd_done_o             (fd_w[m]),
      .done_o                 (done_w[m])
    );
  end

  // Downstream tweakey registers fed back into the DUT.
  always @(posedge clk) begin
    for (int m = 0; m < 3; m++) begin
      if (ld) begin
        r_hi[m] <= ld_hi[m];
        r_lo[m] <= ld_lo[m];
      end else if (enc_w[m]) begin
        r_hi[m] <= sk_hi[m];
        r_lo[m] <= sk_lo[m];
      end else if (se_w[m]) begin
        r_hi[m] <= rv_hi[m];
        r_lo[m] <= rv_lo[m];
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] m_lfsr(input int mode, input logic [7:0] x);
    int v;
    v = int'(x);
    if (mode == 2) v = ((v * 2) % 256) + (((v / 128) + (v / 32)) % 2);
    else if (mode == 3) v = (v / 2) + 128 * ((v + (v / 64)) % 2);
    return 8'(v);
  endfunction

  function automatic logic [127:0] m_fwd(input int mode, input logic [127:0] tk);
    logic [127:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n[8*i +: 8]     = m_lfsr(mode, tk[8*PT[i] +: 8]);
      n[8*(8+i) +: 8] = tk[8*i +: 8];
    end
    return n;
  endfunction

  function automatic logic [127:0] m_inv(input int mode, input logic [127:0] n);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 8; i++) begin
      o[8*i +: 8]     = n[8*(8+i) +: 8];
      o[8*PT[i] +: 8] = inv_tab[mode][n[8*i +: 8]];
    end
    return o;
  endfunction

  typedef enum int {P_IDLE, P_FWD, P_HOLD, P_REV} ph_e;
  ph_e ph = P_IDLE;
  int  ref_e = 0;
  bit  armed = 1'b0;

  always @(posedge clk) edge_n <= edge_n + 1;

  // Phase is tracked from absolute edge numbers: a run always lasts ROUNDS*CYC cycles.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph    <= P_IDLE;
      armed <= 1'b0;
    end else begin
      case (ph)
        P_IDLE: if (start) begin ph <= P_FWD; ref_e <= edge_n; armed <= 1'b0; end
        P_FWD:  if (edge_n - ref_e == ROUNDS * CYC) ph <= P_HOLD;
        P_HOLD: if (revert) begin ph <= P_REV; ref_e <= edge_n; end
        P_REV:  if (edge_n - ref_e == ROUNDS * CYC) begin ph <= P_IDLE; armed <= 1'b1; end
        default: ph <= P_IDLE;
      endcase
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  // Compare process: every cycle, every lane.
  always @(negedge clk) begin
    int c;
    logic [4:0] e_ctl;
    int e_rnd;
    c = edge_n - ref_e;
    e_ctl[4] = (ph == P_FWD) && (c > 0) && (c % CYC == 0);
    e_ctl[3] = (ph == P_REV) && (c > 0) && (c % CYC == 0);
    e_ctl[2] = (ph == P_FWD) || (ph == P_REV);
    e_ctl[1] = (ph == P_HOLD) && (c == ROUNDS * CYC + 1);
    e_ctl[0] = (ph == P_IDLE) && armed && (c == ROUNDS * CYC + 1);
    case (ph)
      P_FWD:   e_rnd = (c - 1) / CYC;
      P_HOLD:  e_rnd = ROUNDS;
      P_REV:   e_rnd = ROUNDS - (c - 1) / CYC;
      default: e_rnd = 0;
    endcase
    for (int m = 0; m < 3; m++) begin
      chk("ctl_flags", {enc_w[m], se_w[m], busy_w[m], fd_w[m], done_w[m]}, e_ctl);
      chk("round", rnd_w[m], e_rnd);
      chk("fwd_dat", {sk_lo[m], sk_hi[m]}, m_fwd(mode_of(m), {t_lo[m], t_hi[m]}));
      chk("inv_dat", {rv_lo[m], rv_hi[m]}, m_inv(mode_of(m), {t_lo[m], t_hi[m]}));
    end
    if (enc_w[0]) begin
      enc_cnt++;
      if (last_enc >= 0) chk("enc_gap", edge_n - last_enc, CYC);
      last_enc = edge_n;
    end
    if (se_w[0]) begin
      se_cnt++;
      if (last_se >= 0) chk("se_gap", edge_n - last_se, CYC);
      last_se = edge_n;
    end
    if (done_w[0]) done_cnt++;
  end

  task automatic load_random();
    @(posedge clk);
    #1;
    for (int m = 0; m < 3; m++) begin
      ld_hi[m]   = {$urandom, $urandom};
      ld_lo[m]   = {$urandom, $urandom};
      init_hi[m] = ld_hi[m];
      init_lo[m] = ld_lo[m];
    end
    ld = 1'b1;
    @(posedge clk);
    #1;
    ld = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int t0;
    bit seen;
    logic [127:0] acc;
    for (int md = 0; md < 4; md++)
      for (int b = 0; b < 256; b++) inv_tab[md][m_lfsr(md, 8'(b))] = 8'(b);
    for (int m = 0; m < 3; m++) begin
      f_hi[m] = '0; f_lo[m] = '0; ld_hi[m] = '0; ld_lo[m] = '0;
    end
    enc_cnt = 0; se_cnt = 0; done_cnt = 0; last_enc = -1; last_se = -1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_state", {enc_w, se_w, busy_w, fd_w, done_w}, 15'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Hand-computed vectors pin both the model and the DUT.
    f_hi[0] = 64'h0706050403020100; f_lo[0] = 64'h0F0E0D0C0B0A0908;
    f_hi[1] = 64'h0000000000000001; f_lo[1] = 64'h0000000000008000;
    f_hi[2] = 64'h0000000000000080; f_lo[2] = 64'h0000000000000100;
    @(negedge clk);
    chk("model_vec", m_fwd(0, {f_lo[0], f_hi[0]}), {64'h0706050403020100, 64'h0B0C0E0A0D080F09});
    chk("tk1_fwd_hi", sk_hi[0], 64'h0B0C0E0A0D080F09);
    chk("tk1_fwd_lo", sk_lo[0], 64'h0706050403020100);
    chk("lfsr2_fwd", {sk_lo[1], sk_hi[1]}, {64'h01, 64'h01});
    chk("lfsr2_inv", {rv_lo[1], rv_hi[1]}, {64'h8000, 64'h8000});
    chk("lfsr3_fwd", {sk_lo[2], sk_hi[2]}, {64'h80, 64'h80});
    chk("lfsr3_inv", {rv_lo[2], rv_hi[2]}, {64'h0100, 64'h0100});
    chk("model_l2", m_lfsr(2, 8'h80), 8'h01);
    chk("model_l3", m_lfsr(3, 8'h01), 8'h80);
    @(posedge clk);
    #1;
    f_hi[0] = 64'h0B0C0E0A0D080F09; f_lo[0] = 64'h0706050403020100;
    @(negedge clk);
    chk("tk1_inv_hi", rv_hi[0], 64'h0706050403020100);
    chk("tk1_inv_lo", rv_lo[0], 64'h0F0E0D0C0B0A0908);
    @(posedge clk);
    #1 force_en = 1'b0;

    // Run aborted by reset at round 17, with ignored start/revert noise.
    load_random();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 0; k < 200 && rnd_w[0] != 6'd17; k++) begin
      @(posedge clk);
      #1;
      start  = ($urandom_range(0, 3) == 0);
      revert = ($urandom_range(0, 3) == 0);
    end
    start = 1'b0; revert = 1'b0;
    chk("reach_r17", rnd_w[0], 6'd17);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_enc_se_busy", {enc_w, se_w, busy_w}, 9'd0);
    chk("midrst_round", rnd_w[0], 6'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Full forward + restore run; start and revert together in IDLE.
    load_random();
    enc_cnt = 0; se_cnt = 0; done_cnt = 0; last_enc = -1; last_se = -1;
    start = 1'b1; revert = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; revert = 1'b0;
    t0 = edge_n;
    seen = 1'b0;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(posedge clk);
      #1;
      if (fd_w[0]) seen = 1'b1;
      else begin
        start  = ($urandom_range(0, 3) == 0);
        revert = ($urandom_range(0, 3) == 0);
      end
    end
    start = 1'b0; revert = 1'b0;
    chk("fwd_done_seen", seen, 1'b1);
    chk("fwd_done_cycle", edge_n - t0 + 1, ROUNDS * CYC + 1);
    chk("enc_count", enc_cnt, ROUNDS);
    for (int m = 0; m < 3; m++) begin
      acc = {init_lo[m], init_hi[m]};
      for (int r = 0; r < ROUNDS; r++) acc = m_fwd(mode_of(m), acc);
      chk("fwd_result", {r_lo[m], r_hi[m]}, acc);
    end

    repeat (5) begin
      @(posedge clk);
      #1 start = $urandom_range(0, 1) == 1;
    end
    start = 1'b0;
    revert = 1'b1;
    @(posedge clk);
    #1 revert = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(posedge clk);
      #1;
      if (done_w[0]) seen = 1'b1;
      else start = ($urandom_range(0, 3) == 0);
    end
    start = 1'b0;
    chk("done_seen", seen, 1'b1);
    chk("se_count", se_cnt, ROUNDS);
    for (int m = 0; m < 3; m++)
      chk("restored", {r_lo[m], r_hi[m]}, {init_lo[m], init_hi[m]});
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("done_count", done_cnt, 1);
    chk("enc_total", enc_cnt, ROUNDS);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
